// File: rtl/gtech_deser8_pkg.sv
// Shared types and constants for the gtech_deser8 serial byte assembler.
package gtech_deser8_pkg;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

    // Register index for serial bit k, honouring the bit-order option.
    function automatic logic [CW-1:0] bit_pos(input logic [CW-1:0] k, input logic lsb_first);
        return lsb_first ? k : CW'(W - 1) - k;
    endfunction

endpackage

// File: rtl/gtech_deser8.sv
// Serial-to-parallel byte assembler with optional parity and valid/ack output.
module gtech_deser8
    import gtech_deser8_pkg::*;
#(
    parameter int unsigned LSB_FIRST  = 1,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic         CP,
    input  logic         CD,
    input  logic         SYNC,
    input  logic         SI,
    input  logic         SI_VLD,
    input  logic         DOUT_ACK,
    output logic [W-1:0] DOUT,
    output logic         DOUT_VLD,
    output logic         BUSY,
    output logic         FERR,
    output logic         PERR,
    output logic         OVR
);

    localparam logic LSB  = (LSB_FIRST != 0);
    localparam logic PEN  = (PARITY_EN != 0);
    localparam logic PODD = (PARITY_ODD != 0);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    sh_q, sh_d;
    logic [W-1:0]    dout_q, dout_d;
    logic            vld_q, vld_d;
    logic            ferr_q, ferr_d;
    logic            perr_q, perr_d;
    logic            ovr_q, ovr_d;

    logic [W-1:0]    sh_ins;
    logic [W-1:0]    sh_first;
    logic [W-1:0]    byte_val;
    logic            byte_done;
    logic            frame_abort;
    logic            par_fail;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: framing, bit placement, parity check; SYNC wins over completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        byte_val    = sh_q;
        byte_done   = 1'b0;
        frame_abort = 1'b0;
        par_fail    = 1'b0;

        sh_ins                      = sh_q;
        sh_ins[bit_pos(cnt_q, LSB)] = SI;
        sh_first                    = '0;
        sh_first[bit_pos('0, LSB)]  = SI;

        if (SI_VLD) begin
            if (SYNC) begin
                frame_abort = (state_q != IDLE);
                sh_d        = sh_first;
                cnt_d       = CW'(1);
                state_d     = SHIFT;
            end else begin
                case (state_q)
                    SHIFT: begin
                        sh_d  = sh_ins;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(W - 1)) begin
                            if (PEN) begin
                                state_d = PAR;
                            end else begin
                                byte_done = 1'b1;
                                byte_val  = sh_ins;
                                state_d   = IDLE;
                            end
                        end
                    end
                    PAR: begin
                        state_d = IDLE;
                        if ((^sh_q ^ SI ^ PODD) == 1'b0) begin
                            byte_done = 1'b1;
                        end else begin
                            par_fail = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Output handshake: load on completion if free or acked this cycle, else overrun.
    always_comb begin
        dout_d = dout_q;
        vld_d  = vld_q;
        ferr_d = frame_abort;
        perr_d = par_fail;
        ovr_d  = 1'b0;
        if (byte_done) begin
            if (!vld_q || DOUT_ACK) begin
                dout_d = byte_val;
                vld_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (DOUT_ACK) begin
            vld_d = 1'b0;
        end
    end

    assign DOUT     = dout_q;
    assign DOUT_VLD = vld_q;
    assign BUSY     = (state_q != IDLE);
    assign FERR     = ferr_q;
    assign PERR     = perr_q;
    assign OVR      = ovr_q;

endmodule

// File: tb/tb_gtech_deser8.sv
// Scoreboard bench for gtech_deser8: four instances covering bit order and parity modes.
module tb_gtech_deser8;

    logic CP = 1'b0;
    logic CD = 1'b0;

    // Group A drives instances 0 (LSB first) and 1 (MSB first); group B drives
    // instances 2 (even parity) and 3 (odd parity).
    logic a_sync = 1'b0, a_si = 1'b0, a_vld = 1'b0, a_ack = 1'b0;
    logic b_sync = 1'b0, b_si = 1'b0, b_vld = 1'b0, b_ack = 1'b0;

    logic [7:0] dout [4];
    logic       vld  [4];
    logic       busy [4];
    logic       ferr [4];
    logic       perr [4];
    logic       ovr  [4];
    logic       ack  [4];

    logic [7:0] exp_q [4][$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CP = ~CP;

    assign ack[0] = a_ack;
    assign ack[1] = a_ack;
    assign ack[2] = b_ack;
    assign ack[3] = b_ack;

    gtech_deser8 #(.LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u_lsb (
        .CP(CP), .CD(CD), .SYNC(a_sync), .SI(a_si), .SI_VLD(a_vld), .DOUT_ACK(a_ack),
        .DOUT(dout[0]), .DOUT_VLD(vld[0]), .BUSY(busy[0]), .FERR(ferr[0]), .PERR(perr[0]), .OVR(ovr[0])
    );
    gtech_deser8 #(.LSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) u_msb (
        .CP(CP), .CD(CD), .SYNC(a_sync), .SI(a_si), .SI_VLD(a_vld), .DOUT_ACK(a_ack),
        .DOUT(dout[1]), .DOUT_VLD(vld[1]), .BUSY(busy[1]), .FERR(ferr[1]), .PERR(perr[1]), .OVR(ovr[1])
    );
    gtech_deser8 #(.LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(0)) u_peven (
        .CP(CP), .CD(CD), .SYNC(b_sync), .SI(b_si), .SI_VLD(b_vld), .DOUT_ACK(b_ack),
        .DOUT(dout[2]), .DOUT_VLD(vld[2]), .BUSY(busy[2]), .FERR(ferr[2]), .PERR(perr[2]), .OVR(ovr[2])
    );
    gtech_deser8 #(.LSB_FIRST(1), .PARITY_EN(1), .PARITY_ODD(1)) u_podd (
        .CP(CP), .CD(CD), .SYNC(b_sync), .SI(b_si), .SI_VLD(b_vld), .DOUT_ACK(b_ack),
        .DOUT(dout[3]), .DOUT_VLD(vld[3]), .BUSY(busy[3]), .FERR(ferr[3]), .PERR(perr[3]), .OVR(ovr[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7 - i] = v[i];
        return r;
    endfunction

    // Every accepted byte must match the oldest outstanding expectation.
    always @(negedge CP) begin
        if (CD) begin
            for (int i = 0; i < 4; i++) begin
                if (vld[i] && ack[i]) begin
                    if (exp_q[i].size() == 0)
                        chk($sformatf("sb%0d_unexpected", i), 32'd0, 32'd1);
                    else
                        chk($sformatf("sb%0d_dout", i), {24'd0, dout[i]}, {24'd0, exp_q[i].pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // One SI_VLD cycle on group g; returns 1 time unit after the sampling edge.
    task automatic bit_g(input int unsigned g, input logic s, input logic d);
        if (g == 0) begin a_sync = s; a_si = d; a_vld = 1'b1; end
        else        begin b_sync = s; b_si = d; b_vld = 1'b1; end
        @(posedge CP); #1;
        a_vld = 1'b0; a_sync = 1'b0; b_vld = 1'b0; b_sync = 1'b0;
    endtask

    task automatic bits_g(input int unsigned g, input logic [7:0] v, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) bit_g(g, (k == 0), v[k]);
    endtask

    task automatic ack_g(input int unsigned g);
        if (g == 0) a_ack = 1'b1; else b_ack = 1'b1;
        @(posedge CP); #1;
        a_ack = 1'b0; b_ack = 1'b0;
    endtask

    // Idle cycle with junk on SYNC/SI while the qualifier is low.
    task automatic gap_a();
        a_vld = 1'b0; a_sync = 1'b1; a_si = 1'($urandom_range(0, 1));
        @(posedge CP); #1;
        a_sync = 1'b0;
    endtask

    task automatic chk_all_zero(input string when);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_dout%0d", when, i), {24'd0, dout[i]}, 32'd0);
            chk($sformatf("%s_vld%0d", when, i),  {31'd0, vld[i]},  32'd0);
            chk($sformatf("%s_busy%0d", when, i), {31'd0, busy[i]}, 32'd0);
            chk($sformatf("%s_ferr%0d", when, i), {31'd0, ferr[i]}, 32'd0);
            chk($sformatf("%s_perr%0d", when, i), {31'd0, perr[i]}, 32'd0);
            chk($sformatf("%s_ovr%0d", when, i),  {31'd0, ovr[i]},  32'd0);
        end
    endtask

    initial begin
        logic [7:0] v;

        #2;
        chk_all_zero("rst");
        @(negedge CP); CD = 1'b1;
        @(posedge CP); #1;

        // Unframed bits in IDLE are ignored.
        bit_g(0, 1'b0, 1'b1);
        bit_g(0, 1'b0, 1'b1);
        chk("idle_busy", {31'd0, busy[0]}, 32'd0);

        // Basic frame 1,0,1,1,0,0,1,0 in both bit orders.
        v = 8'h4D;
        exp_q[0].push_back(v);
        exp_q[1].push_back(rev8(v));
        bit_g(0, 1'b1, v[0]);
        chk("busy_first", {31'd0, busy[0]}, 32'd1);
        bits_g(0, v, 1, 6);
        chk("vld_before_last", {31'd0, vld[0]}, 32'd0);
        bit_g(0, 1'b0, v[7]);
        chk("vld_lsb", {31'd0, vld[0]}, 32'd1);
        chk("vld_msb", {31'd0, vld[1]}, 32'd1);
        chk("dout_lsb", {24'd0, dout[0]}, 32'h4D);
        chk("dout_msb", {24'd0, dout[1]}, 32'hB2);
        chk("busy_done", {31'd0, busy[0]}, 32'd0);
        ack_g(0);
        chk("ack_clr", {31'd0, vld[0]}, 32'd0);
        chk("ack_hold", {24'd0, dout[0]}, 32'h4D);

        // SYNC after four bits aborts the frame; old ones must not leak.
        bit_g(0, 1'b1, 1'b1);
        bits_g(0, 8'hFF, 1, 3);
        v = 8'h06;
        exp_q[0].push_back(v);
        exp_q[1].push_back(rev8(v));
        bit_g(0, 1'b1, v[0]);
        chk("ferr_pulse", {31'd0, ferr[0]}, 32'd1);
        chk("ferr_pulse_msb", {31'd0, ferr[1]}, 32'd1);
        bit_g(0, 1'b0, v[1]);
        chk("ferr_clear", {31'd0, ferr[0]}, 32'd0);
        bits_g(0, v, 2, 7);
        chk("ferr_newbyte", {24'd0, dout[0]}, 32'h06);
        ack_g(0);

        // Overrun: second byte dropped while the first is un-acked.
        exp_q[0].push_back(8'h11);
        exp_q[1].push_back(rev8(8'h11));
        bits_g(0, 8'h11, 0, 7);
        bits_g(0, 8'h22, 0, 7);
        chk("ovr_pulse", {31'd0, ovr[0]}, 32'd1);
        chk("ovr_dout", {24'd0, dout[0]}, 32'h11);
        chk("ovr_vld", {31'd0, vld[0]}, 32'd1);
        bit_g(0, 1'b0, 1'b0);
        chk("ovr_clear", {31'd0, ovr[0]}, 32'd0);
        ack_g(0);
        chk("ovr_acked", {31'd0, vld[0]}, 32'd0);

        // Same-cycle ack on completion replaces the held byte.
        exp_q[0].push_back(8'h11);
        exp_q[1].push_back(rev8(8'h11));
        bits_g(0, 8'h11, 0, 7);
        v = 8'h22;
        bits_g(0, v, 0, 6);
        exp_q[0].push_back(v);
        exp_q[1].push_back(rev8(v));
        a_ack = 1'b1;
        bit_g(0, 1'b0, v[7]);
        a_ack = 1'b0;
        chk("sameack_ovr", {31'd0, ovr[0]}, 32'd0);
        chk("sameack_dout", {24'd0, dout[0]}, 32'h22);
        chk("sameack_vld", {31'd0, vld[0]}, 32'd1);
        ack_g(0);

        // Gaps with junk inputs inside a frame.
        v = 8'hC3;
        exp_q[0].push_back(v);
        exp_q[1].push_back(rev8(v));
        for (int k = 0; k < 8; k++) begin
            bit_g(0, (k == 0), v[k]);
            if (k < 7) begin
                gap_a();
                chk($sformatf("gap_busy%0d", k), {31'd0, busy[0]}, 32'd1);
                chk($sformatf("gap_ferr%0d", k), {31'd0, ferr[0]}, 32'd0);
            end
        end
        chk("gap_vld", {31'd0, vld[0]}, 32'd1);
        ack_g(0);

        // Reset with an un-acked byte and a partial frame in flight.
        bits_g(0, 8'h5A, 0, 7);
        bits_g(0, 8'hFF, 0, 3);
        #2 CD = 1'b0;
        #1 chk_all_zero("mid_rst");
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        @(negedge CP); CD = 1'b1;
        @(posedge CP); #1;
        v = 8'hA5;
        exp_q[0].push_back(v);
        exp_q[1].push_back(rev8(v));
        bits_g(0, v, 0, 7);
        chk("post_rst_dout", {24'd0, dout[0]}, 32'hA5);
        ack_g(0);

        // Parity: 0x4D has four ones.
        v = 8'h4D;
        exp_q[2].push_back(v);
        bits_g(1, v, 0, 7);
        chk("par_busy_wait", {31'd0, busy[2]}, 32'd1);
        chk("par_vld_wait", {31'd0, vld[2]}, 32'd0);
        bit_g(1, 1'b0, 1'b0);
        chk("peven_vld", {31'd0, vld[2]}, 32'd1);
        chk("peven_perr", {31'd0, perr[2]}, 32'd0);
        chk("podd_perr", {31'd0, perr[3]}, 32'd1);
        chk("podd_vld", {31'd0, vld[3]}, 32'd0);
        chk("par_busy_done", {31'd0, busy[2]}, 32'd0);
        ack_g(1);
        chk("podd_perr_clear", {31'd0, perr[3]}, 32'd0);

        exp_q[3].push_back(v);
        bits_g(1, v, 0, 7);
        bit_g(1, 1'b0, 1'b1);
        chk("peven_perr1", {31'd0, perr[2]}, 32'd1);
        chk("peven_vld1", {31'd0, vld[2]}, 32'd0);
        chk("podd_vld1", {31'd0, vld[3]}, 32'd1);
        ack_g(1);

        // SYNC in place of the parity bit aborts the frame.
        bits_g(1, 8'h4D, 0, 7);
        v = 8'h81;
        exp_q[2].push_back(v);
        bit_g(1, 1'b1, v[0]);
        chk("par_ferr_even", {31'd0, ferr[2]}, 32'd1);
        chk("par_ferr_odd", {31'd0, ferr[3]}, 32'd1);
        chk("par_ferr_noperr", {31'd0, perr[3]}, 32'd0);
        bits_g(1, v, 1, 7);
        bit_g(1, 1'b0, 1'b0);
        chk("par_new_even", {24'd0, dout[2]}, 32'h81);
        chk("par_new_odd_perr", {31'd0, perr[3]}, 32'd1);
        ack_g(1);

        for (int i = 0; i < 4; i++)
            chk($sformatf("sb%0d_drained", i), 32'(exp_q[i].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gtech_deser8.md
# gtech_deser8

Serial-to-parallel byte assembler that feeds the 8-bit parallel register bank with asynchronous clear and set. It collects framed serial bits, optionally checks a parity bit, and presents a complete byte on `DOUT[7:0]` with a valid/ack handshake. `DOUT` maps to the register bank's D0..D7 inputs, and `DOUT_VLD & DOUT_ACK` acts as its load qualifier.

## Interface
Parameters:
- `LSB_FIRST`, default 1: 1 = first serial bit lands in `DOUT[0]`; 0 = first bit lands in `DOUT[7]`.
- `PARITY_EN`, default 0: 1 = a parity bit follows the 8 data bits.
- `PARITY_ODD`, default 0: 0 = even parity (data plus parity has an even count of ones); 1 = odd parity.

Ports (one clock; reset is asynchronous and active-low):
- `CP  in  1` — clock, rising edge.
- `CD  in  1` — asynchronous active-low reset.
- `SYNC  in  1` — frame start; qualified by `SI_VLD`, marks the current bit as data bit 0 of a new frame.
- `SI  in  1` — serial data bit.
- `SI_VLD  in  1` — bit qualifier; `SI` and `SYNC` are ignored when low.
- `DOUT_ACK  in  1` — downstream accepts `DOUT` on a rising `CP` edge where `DOUT_VLD=1`.
- `DOUT  out  8` — assembled byte.
- `DOUT_VLD  out  1` — byte valid; held until acked.
- `BUSY  out  1` — frame in progress (state is not IDLE).
- `FERR  out  1` — one-cycle pulse: frame aborted by `SYNC`.
- `PERR  out  1` — one-cycle pulse: parity mismatch, byte dropped.
- `OVR  out  1` — one-cycle pulse: byte completed while the previous byte was un-acked; new byte dropped.

## Operation
- States:
  - IDLE, SHIFT, PAR.
  - 3-bit bit counter `cnt`.
  - 8-bit shift register `sh`.
- IDLE:
  - `SI_VLD & SYNC` → capture `SI` as bit 0, `cnt=1`, go to SHIFT.
  - `SI_VLD` without `SYNC` → ignored.
- SHIFT, on each `SI_VLD`:
  - Without `SYNC`: store `SI` at position `cnt`, `cnt++`.
  - When the 8th bit is stored (`cnt` was 7): go to PAR if `PARITY_EN`, else complete and go to IDLE.
- PAR, on `SI_VLD`:
  - Parity check passes → complete, go to IDLE.
  - Check fails → `PERR` pulse, byte dropped, go to IDLE.
- `SYNC & SI_VLD` in SHIFT or PAR:
  - `FERR` pulse; partial frame discarded.
  - The current bit becomes bit 0 of a new frame: `cnt=1`, state SHIFT.
  - `SYNC` takes priority over completion.
- Bit placement:
  - `LSB_FIRST=1`: bit k → `DOUT[k]`.
  - `LSB_FIRST=0`: bit k → `DOUT[7-k]`.
- Completion, when `DOUT_VLD=0` or `DOUT_ACK=1` in the same cycle:
  - `DOUT` ← assembled byte; `DOUT_VLD=1`.
- Completion when `DOUT_VLD=1` and `DOUT_ACK=0`:
  - `OVR` pulse; `DOUT` unchanged; `DOUT_VLD` stays 1.
- Ack without completion: `DOUT_VLD` → 0; `DOUT` holds its last value.
- `SI_VLD=0` cycles (gaps) inside a frame: state and `cnt` hold; no timeout.

## Timing
- Reset values, asserted immediately on `CD` low regardless of `CP`:
  - `DOUT=8'h00`; `DOUT_VLD`, `BUSY`, `FERR`, `PERR`, `OVR` all 0.
  - State IDLE, `cnt=0`, `sh=0`.
- Reset mid-frame discards the partial byte and any un-acked `DOUT`.
- All state changes occur on rising `CP` edges while `CD=1`.
- Latency:
  - `DOUT_VLD` rises on the edge that samples the last data bit (no parity) or the parity bit.
  - Minimum frame is 8 `SI_VLD` cycles (9 with parity).
  - Back-to-back frames are allowed: a `SYNC` bit may immediately follow the final bit.
- `BUSY` is registered: high from the edge that samples the `SYNC` bit until the edge that samples the final bit.
- `FERR`, `PERR` and `OVR` are registered and high for exactly one cycle.

## Structure
- Package `gtech_deser8_pkg`:
  - State encoding constants IDLE=2'd0, SHIFT=2'd1, PAR=2'd2.
  - Byte width constant `W=8`; counter width 3.
- Single module; no sub-module. The shift/counter logic is small enough to stay flat.
- Parity is computed as XOR-reduce of `sh` combined with `SI` and `PARITY_ODD`.

## Test plan
- LSB-first, no parity:
  - Stimulus: `SYNC` with bits 1,0,1,1,0,0,1,0 on consecutive cycles.
  - Response: `DOUT=8'h4D`, `DOUT_VLD=1` one edge after bit 7.
  - `DOUT_ACK` clears `DOUT_VLD` on the next edge.
- `LSB_FIRST=0`, same bits → `DOUT=8'hB2`.
- `PARITY_EN=1`, even parity:
  - Byte `8'h4D` with parity bit 0 → accepted.
  - Same byte with parity bit 1 → `PERR` pulse, `DOUT_VLD` stays 0.
- `SYNC` after 4 bits of a frame:
  - `FERR` pulse; the new frame of 8 bits gives the correct byte.
  - Old bits must not appear in `DOUT`.
- Overrun and same-cycle ack:
  - Two back-to-back frames `8'h11` then `8'h22` with no ack → `OVR` pulse, `DOUT=8'h11`.
  - Repeat with ack on the completion cycle → `DOUT=8'h22`, `DOUT_VLD` stays 1.
- `CD` pulsed low mid-frame and while `DOUT_VLD=1`:
  - All outputs 0 immediately, without a `CP` edge.
  - The next `SYNC` frame assembles correctly.
